// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_send transmitter between NUM_REQ byte producers.
//   Producers are granted round-robin (or fixed priority, see below) and the
//   winning byte is handed to uart_send as a one-cycle valid/data pulse.
//   uart_send has no busy output, so after each issue this block waits a
//   full frame plus a guard interval before it arbitrates again.
//
//   Optional feature macro: UART_TX_ARBITER_FIXED_PRIO_EN
//     defined   : lowest requesting index always wins (no rotating pointer)
//     undefined : round-robin starting after the last granted requester
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   req       in   [NUM_REQ-1:0]    requester i has a byte pending
//   req_data  in   [8*NUM_REQ-1:0]  byte of requester i at [8*i+7:8*i]
//   gnt       out  [NUM_REQ-1:0]    one-hot 1-cycle pulse, byte i consumed
//   tx_valid  out                   to uart_send.valid, 1-cycle pulse
//   tx_data   out  [7:0]            to uart_send.data, held after the pulse
//   busy      out                   high whenever the FSM is not IDLE

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int FRAME_BITS   = 10,
    parameter int GUARD_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 busy
);

    localparam int WAIT_CYCLES = CLKS_PER_BIT * (FRAME_BITS + GUARD_BITS);
    localparam int CNT_W       = $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W       = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   winner;

`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
    // Lowest index wins: scan downward so the last hit is the smallest i.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
    logic             found;
    int               idx;

    // Search starts one past the last grant and wraps, so the most recently
    // served requester has the lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d        = ISSUE;
                    gnt_d[winner]  = 1'b1;
                    tx_valid_d     = 1'b1;
                    tx_data_d      = req_data[8*int'(winner) +: 8];
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
                    last_gnt_d     = winner;
`endif
                end
            end
            ISSUE: begin
                // gnt/tx_valid fall back to 0 via the defaults above.
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
            WAIT: begin
                // req is ignored here; the frame must fully drain first.
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a small behavioural uart_send attached.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int CPB         = 4;
    localparam int FB          = 10;
    localparam int GB          = 1;
    localparam int WAIT_CYCLES = CPB * (FB + GB);
    localparam int SPACING     = WAIT_CYCLES + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int model_last = NUM_REQ - 1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GUARD_BITS(GB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy)
    );

    // Behavioural uart_send: free-running baud tick, frame starts on the
    // first tick after valid, 10 bits each one bit time long.
    int         bc;
    logic       u_pending, u_active, dout;
    int         u_bits, frames_started, frames_done;
    logic [9:0] u_sh;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bc <= 0; u_pending <= 1'b0; u_active <= 1'b0; dout <= 1'b1;
            u_bits <= 0; u_sh <= '1; frames_started <= 0; frames_done <= 0;
        end else begin
            bc <= (bc == CPB - 1) ? 0 : bc + 1;
            if (bc == CPB - 1) begin
                if (u_active) begin
                    if (u_bits == FB) begin
                        u_active <= 1'b0; dout <= 1'b1; u_bits <= 0;
                        frames_done <= frames_done + 1;
                    end else begin
                        dout <= u_sh[u_bits]; u_bits <= u_bits + 1;
                    end
                end else if (u_pending) begin
                    u_pending <= 1'b0; u_active <= 1'b1;
                    dout <= u_sh[0]; u_bits <= 1;
                end
            end
            if (tx_valid) begin
                u_pending <= 1'b1;
                u_sh <= {1'b1, tx_data, 1'b0};
                frames_started <= frames_started + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output-relationship checks on every cycle, plus frame overlap check.
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("gnt_vs_valid", 32'(|gnt), 32'(tx_valid));
            if (tx_valid) begin
                chk("valid_busy", 32'(busy), 32'd1);
                chk("uart_overlap", 32'(u_active | u_pending), 32'd0);
                chk("uart_frames_complete", 32'(frames_done), 32'(frames_started));
            end
        end
    end

    // Arbitration rule from the priority order: candidates listed in the
    // order they are considered, first requesting one wins.
    function automatic int pick(input logic [3:0] r, input int last);
        int order[$];
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
        order = '{0, 1, 2, 3};
`else
        order = {};
        for (int k = 1; k <= NUM_REQ; k++) order.push_back((last + k) % NUM_REQ);
`endif
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!tx_valid && cyc < 300);
        if (!tx_valid) chk("pulse_timeout", 32'(cyc), 32'd0);
    endtask

    // Waits for the next issue and checks grant, data and spacing.
    task automatic issue_check(input string tag, input int exp_cyc);
        int c, w;
        logic [3:0] r;
        logic [31:0] d;
        r = req; d = req_data;
        wait_pulse(c);
        w = pick(r, model_last);
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
        chk({tag, "_data"}, 32'(tx_data), 32'(d[8*w +: 8]));
        chk({tag, "_spacing"}, 32'(c), 32'(exp_cyc));
        model_last = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_last = NUM_REQ - 1;
    endtask

    initial begin
        int n, pulses;

        // Reset values
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(); step();
        chk("idle_no_req", 32'({busy, tx_valid, gnt}), 32'd0);

        // 1: single byte, latency 1, busy for 45 cycles
        req = 4'b0001; req_data = 32'h0000_00A5;
        issue_check("t1", 1);
        req = '0;
        n = 0;
        while (busy && n < 100) begin n++; step(); end
        chk("t1_busy_len", 32'(n), 32'(WAIT_CYCLES + 1));
        chk("t1_idle_out", 32'({busy, tx_valid, gnt}), 32'd0);
        chk("t1_data_hold", 32'(tx_data), 32'hA5);

        // 2: all requesting from reset pointer
        do_reset();
        req = 4'b1111; req_data = 32'h4433_2211;
        issue_check("t2_0", 1);
        for (int i = 1; i < 5; i++) issue_check("t2_n", SPACING);
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
        chk("t2_wrap_data", 32'(tx_data), 32'h11);
`endif

        // 3: requester 2 only, held for three bytes
        req = 4'b0100; req_data = 32'h00C3_0000;
        for (int i = 0; i < 3; i++) issue_check("t3", SPACING);

        // 4: request raised and withdrawn during WAIT
        req = '0;
        for (int i = 0; i < 5; i++) step();
        req = 4'b0010; req_data = 32'h0000_5A00;
        for (int i = 0; i < 10; i++) step();
        req = '0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin step(); if (tx_valid) pulses++; end
        chk("t4_no_pulse", 32'(pulses), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);

        // 5: reset in the 10th WAIT cycle with 0011 pending
        req = 4'b0011; req_data = 32'h0000_7766;
        issue_check("t5_pre", 1);
        for (int i = 0; i < 10; i++) step();
        chk("t5_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out", 32'({busy, tx_valid, gnt}), 32'd0);
        chk("t5_rst_data", 32'(tx_data), 32'd0);
        step(); step();
        rst = 1'b0;
        model_last = NUM_REQ - 1;
        issue_check("t5_post", 1);
        chk("t5_first_req0", 32'(gnt), 32'b0001);

        // Random requests, each posted right after the previous grant
        for (int i = 0; i < 16; i++) begin
            req = 4'($urandom_range(1, 15));
            req_data = $urandom;
            issue_check("rnd", SPACING);
        end

`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
        // 6: fixed priority keeps serving requester 0
        req = 4'b0011; req_data = 32'h0000_BBAA;
        for (int i = 0; i < 3; i++) begin
            issue_check("t6", SPACING);
            chk("t6_gnt0", 32'(gnt), 32'b0001);
        end
`endif

        req = '0;
        n = 0;
        while ((busy || u_active || u_pending) && n < 200) begin n++; step(); end
        chk("end_idle", 32'(busy), 32'd0);
        chk("end_frames", 32'(frames_done), 32'(frames_started));
        chk("end_dout_idle", 32'(dout), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
